uart_receiver: RTL and testbench

Serial-to-parallel receive path of the UART peripheral, the counterpart of the transmit shifter. It synchronizes the asynchronous `rxd` line and detects start bits using the 16x oversampling strobe from the sample clock counter. It then samples data, parity and stop bits at mid-bit and delivers each frame into a one-entry holding register with per-frame error flags. The register interface drains the holding register into the RX queue via `rx_re`.

---
 rtl/uart_receiver.sv | 158 +++++++++++++++
 tb/tb_uart_receiver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive path: rxd synchronizer, oversampled start detect,
// mid-bit sampling and a one-entry holding register with error flags.
module uart_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rxd,
  input  logic [1:0] data_bits_count,
  input  logic [1:0] parity_type,
  input  logic       double_stop_bits,
  input  logic       rx_re,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rs, rs_d;
  logic [CW-1:0]          cnt;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   acc;
  logic                   pend_perr, pend_ferr;
  logic [1:0]             dbits_q;
  logic                   par_en_q, par_odd_q, dbl_q;

  logic start_edge, half, mid, last_bit, done, ferr_now;

  assign rs         = sync_q[SYNC_STAGES-1];
  assign start_edge = rs_d & ~rs;
  assign half       = sample_tick && (cnt == HALF);
  assign mid        = sample_tick && (cnt == LAST);
  assign last_bit   = bitcnt == ({1'b0, dbits_q} + 3'd4);
  assign done       = mid && ((state == STOP1 && !dbl_q) ||
                              state == STOP2);
  assign ferr_now   = pend_ferr | ~rs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      rs_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      rs_d   <= rs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start_edge) state_nx = START;
      START:  if (half) state_nx = rs ? IDLE : DATA;
      DATA:   if (mid && last_bit)
                state_nx = par_en_q ? PARITY : STOP1;
      PARITY: if (mid) state_nx = STOP1;
      STOP1:  if (mid) state_nx = dbl_q ? STOP2 : IDLE;
      STOP2:  if (mid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      acc       <= 1'b0;
      pend_perr <= 1'b0;
      pend_ferr <= 1'b0;
      dbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      dbl_q     <= 1'b0;
    end else if (state == IDLE) begin
      if (start_edge) begin
        cnt       <= '0;
        acc       <= 1'b0;
        pend_perr <= 1'b0;
        pend_ferr <= 1'b0;
        dbits_q   <= data_bits_count;
        par_en_q  <= parity_type[0];
        par_odd_q <= parity_type[1];
        dbl_q     <= double_stop_bits;
      end
    end else if (sample_tick) begin
      if (state == START && half) begin
        cnt    <= '0;
        bitcnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (mid) begin
        unique case (1'b1)
          state == DATA: begin
            shreg  <= {rs, shreg[7:1]};
            acc    <= acc ^ rs;
            bitcnt <= bitcnt + 3'd1;
          end
          state == PARITY:
            if (rs != (acc ^ par_odd_q)) pend_perr <= 1'b1;
          state == STOP1 || state == STOP2:
            if (!rs) pend_ferr <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // A read in the completion cycle frees the slot for the new frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      if (!rx_valid || rx_re) begin
        rx_data    <= shreg >> (3'd3 - {1'b0, dbits_q});
        parity_err <= pend_perr;
        frame_err  <= ferr_now;
        rx_valid   <= 1'b1;
        if (rx_re) overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_re && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frame formats, errors,
// glitch rejection, overrun and asynchronous reset.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] data_bits_count = 2'd3;
  logic [1:0] parity_type = 2'd0;
  logic       double_stop_bits = 1'b0;
  logic       rx_re = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;

  int  nvec = 0;
  int  nerr = 0;
  bit  tick1 = 1'b0;

  uart_receiver dut (
    .clk(clk),
    .reset(reset),
    .sample_tick(sample_tick),
    .rxd(rxd),
    .data_bits_count(data_bits_count),
    .parity_type(parity_type),
    .double_stop_bits(double_stop_bits),
    .rx_re(rx_re),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    sample_tick = tick1 ? 1'b1 : ~sample_tick;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bits LSB first; one bit held for a full bit period.
  task automatic send(input logic [15:0] bits, input int nb,
                      input int re_at, input int stop_at);
    int bp;
    int total;
    bp = tick1 ? 16 : 32;
    total = (stop_at > 0) ? stop_at : nb * bp;
    for (int i = 0; i < total; i++) begin
      rxd = bits[i / bp];
      rx_re = (i == re_at);
      @(negedge clk);
    end
    rx_re = 1'b0;
    if (stop_at == 0) begin
      rxd = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic read_pulse();
    rx_re = 1'b1;
    @(negedge clk);
    rx_re = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", {7'd0, rx_valid}, 8'd0);
    chk("rst_perr", {7'd0, parity_err}, 8'd0);
    chk("rst_ferr", {7'd0, frame_err}, 8'd0);
    chk("rst_ovr", {7'd0, overrun}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0xA5
    data_bits_count = 2'd3;
    parity_type = 2'd0;
    double_stop_bits = 1'b0;
    send({6'd0, 1'b1, 8'hA5, 1'b0}, 10, -1, 0);
    chk("8n1_data", rx_data, 8'hA5);
    chk("8n1_valid", {7'd0, rx_valid}, 8'd1);
    chk("8n1_perr", {7'd0, parity_err}, 8'd0);
    chk("8n1_ferr", {7'd0, frame_err}, 8'd0);
    chk("8n1_ovr", {7'd0, overrun}, 8'd0);
    chk("8n1_busy", {7'd0, busy}, 8'd0);
    read_pulse();
    chk("8n1_rd_valid", {7'd0, rx_valid}, 8'd0);
    chk("8n1_rd_data", rx_data, 8'hA5);

    // glitch: 5 ticks low
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    chk("gl_busy_hi", {7'd0, busy}, 8'd1);
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (60) @(negedge clk);
    chk("gl_busy_lo", {7'd0, busy}, 8'd0);
    chk("gl_valid", {7'd0, rx_valid}, 8'd0);
    chk("gl_perr", {7'd0, parity_err}, 8'd0);
    chk("gl_ferr", {7'd0, frame_err}, 8'd0);
    chk("gl_ovr", {7'd0, overrun}, 8'd0);

    // 7E1 0x41, good then bad parity
    data_bits_count = 2'd2;
    parity_type = 2'b01;
    send({6'd0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, -1, 0);
    chk("7e_ok_data", rx_data, 8'h41);
    chk("7e_ok_perr", {7'd0, parity_err}, 8'd0);
    chk("7e_ok_valid", {7'd0, rx_valid}, 8'd1);
    read_pulse();
    send({6'd0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, -1, 0);
    chk("7e_bad_data", rx_data, 8'h41);
    chk("7e_bad_perr", {7'd0, parity_err}, 8'd1);
    chk("7e_bad_ferr", {7'd0, frame_err}, 8'd0);
    read_pulse();

    // 5O2 0x1F, second stop bit low
    data_bits_count = 2'd0;
    parity_type = 2'b11;
    double_stop_bits = 1'b1;
    send({7'd0, 1'b0, 1'b1, 1'b0, 5'h1F, 1'b0}, 9, -1, 0);
    chk("5o2_data", rx_data, 8'h1F);
    chk("5o2_ferr", {7'd0, frame_err}, 8'd1);
    chk("5o2_perr", {7'd0, parity_err}, 8'd0);
    read_pulse();

    // overrun, one tick per clock
    tick1 = 1'b1;
    data_bits_count = 2'd3;
    parity_type = 2'd0;
    double_stop_bits = 1'b0;
    send({6'd0, 1'b1, 8'h11, 1'b0}, 10, -1, 0);
    send({6'd0, 1'b1, 8'h22, 1'b0}, 10, -1, 0);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", {7'd0, overrun}, 8'd1);
    chk("ovr_valid", {7'd0, rx_valid}, 8'd1);
    chk("ovr_ferr", {7'd0, frame_err}, 8'd0);
    read_pulse();
    chk("ovr_rd_valid", {7'd0, rx_valid}, 8'd0);
    chk("ovr_rd_flag", {7'd0, overrun}, 8'd0);
    send({6'd0, 1'b1, 8'h11, 1'b0}, 10, -1, 0);
    send({6'd0, 1'b1, 8'h33, 1'b0}, 10, -1, 0);
    chk("ovr2_flag", {7'd0, overrun}, 8'd1);
    // stop bit sampled at the 155th clock after the start edge
    send({6'd0, 1'b1, 8'h22, 1'b0}, 10, 154, 0);
    chk("sim_data", rx_data, 8'h22);
    chk("sim_valid", {7'd0, rx_valid}, 8'd1);
    chk("sim_ovr", {7'd0, overrun}, 8'd0);

    // reset in the middle of DATA
    send({6'd0, 1'b1, 8'h3C, 1'b0}, 10, -1, 60);
    chk("mid_busy", {7'd0, busy}, 8'd1);
    reset = 1'b0;
    rxd = 1'b1;
    #1;
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_valid", {7'd0, rx_valid}, 8'd0);
    chk("mrst_ovr", {7'd0, overrun}, 8'd0);
    chk("mrst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    tick1 = 1'b0;
    send({6'd0, 1'b1, 8'h3C, 1'b0}, 10, -1, 0);
    chk("post_data", rx_data, 8'h3C);
    chk("post_valid", {7'd0, rx_valid}, 8'd1);
    chk("post_perr", {7'd0, parity_err}, 8'd0);
    chk("post_ferr", {7'd0, frame_err}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
